// File: rtl/pool1_fmap_buffer.sv
// pool1_fmap_buffer: captures NUM_CH pooled int8 maps into RAM, then replays the whole buffer REPLAY_PASSES times as one valid/ready raster stream.
module pool1_fmap_buffer #(
  parameter int NUM_CH        = 6,
  parameter int MAP_W         = 14,
  parameter int REPLAY_PASSES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         valid_in,
  input  logic [NUM_CH*8-1:0]       pixel_in,
  input  logic                      replay_start,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_pixel,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic                      out_last_map,
  output logic                      out_last,
  output logic                      buf_full,
  output logic                      replay_done,
  output logic                      overflow_err
);
  localparam int DEPTH = MAP_W * MAP_W;
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(NUM_CH);
  localparam int PW = $clog2(REPLAY_PASSES);
  localparam int EW = 8 + CW + 2;
  typedef enum logic [1:0] {IDLE, CAPTURE, FULL, REPLAY} state_t;
  state_t state_q, state_d;
  logic [WW-1:0] wcnt_q [NUM_CH];
  logic [7:0] mem [NUM_CH][DEPTH];
  logic [7:0] rd_data_q;
  logic [AW-1:0] idx_q;
  logic [CW-1:0] ch_q;
  logic [PW-1:0] pass_q;
  logic [CW+1:0] rd_meta_q;
  logic [EW-1:0] e0_q, e1_q, e0_d, e1_d, new_e;
  logic [1:0] occ_q, occ_d, occ_pop;
  logic [NUM_CH-1:0] wr;
  logic all_done, last_idx, last_ch, last_pass, last_all, issue, pop, fin;
  logic iss_done_q, rd_v_q, replay_done_q, overflow_q;
  always_comb begin
    all_done = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      wr[c] = (state_q == IDLE || state_q == CAPTURE) && valid_in[c] && wcnt_q[c] != WW'(DEPTH);
      all_done = all_done && (wcnt_q[c] + WW'(wr[c])) == WW'(DEPTH);
    end
  end
  assign last_idx  = idx_q == AW'(DEPTH - 1);
  assign last_ch   = ch_q == CW'(NUM_CH - 1);
  assign last_pass = pass_q == PW'(REPLAY_PASSES - 1);
  assign last_all  = last_idx && last_ch && last_pass;
  assign out_valid = occ_q != 2'd0;
  assign pop       = out_valid && out_ready;
  assign fin       = pop && e0_q[0];
  // Two-entry skid: e0 is the presented beat; a read is issued only if its data is guaranteed a slot.
  assign occ_pop = occ_q - {1'b0, pop};
  assign occ_d   = occ_pop + {1'b0, rd_v_q};
  assign issue   = (state_q == FULL && replay_start) || (state_q == REPLAY && !iss_done_q && occ_d != 2'd2);
  assign new_e   = {rd_data_q, rd_meta_q};
  assign e0_d    = rd_v_q && occ_pop == 2'd0 ? new_e : pop ? e1_q : e0_q;
  assign e1_d    = rd_v_q && occ_pop != 2'd0 ? new_e : e1_q;
  assign state_d = state_q == IDLE    ? (|valid_in ? CAPTURE : IDLE) :
                   state_q == CAPTURE ? (all_done ? FULL : CAPTURE) :
                   state_q == FULL    ? (replay_start ? REPLAY : FULL) :
                                        (fin ? IDLE : REPLAY);
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++)
      if (wr[c]) mem[c][wcnt_q[c][AW-1:0]] <= pixel_in[8*c +: 8];
    rd_data_q <= mem[ch_q][idx_q];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      for (int c = 0; c < NUM_CH; c++) wcnt_q[c] <= '0;
      idx_q         <= '0;
      ch_q          <= '0;
      pass_q        <= '0;
      iss_done_q    <= 1'b0;
      rd_v_q        <= 1'b0;
      rd_meta_q     <= '0;
      occ_q         <= '0;
      e0_q          <= '0;
      e1_q          <= '0;
      replay_done_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int c = 0; c < NUM_CH; c++) wcnt_q[c] <= fin ? '0 : wcnt_q[c] + WW'(wr[c]);
      if (issue) begin
        idx_q  <= last_idx ? '0 : idx_q + 1'b1;
        ch_q   <= last_idx ? (last_ch ? '0 : ch_q + 1'b1) : ch_q;
        pass_q <= last_idx && last_ch ? (last_pass ? '0 : pass_q + 1'b1) : pass_q;
      end
      iss_done_q    <= fin ? 1'b0 : iss_done_q || (issue && last_all);
      rd_v_q        <= issue;
      rd_meta_q     <= {ch_q, last_idx, last_all};
      occ_q         <= occ_d;
      e0_q          <= e0_d;
      e1_q          <= e1_d;
      replay_done_q <= fin;
      overflow_q    <= overflow_q || |(valid_in & ~wr);
    end
  end
  assign {out_pixel, out_ch, out_last_map, out_last} = e0_q;
  assign buf_full     = state_q == FULL;
  assign replay_done  = replay_done_q;
  assign overflow_err = overflow_q;
endmodule

// File: tb/tb_pool1_fmap_buffer.sv
// tb_pool1_fmap_buffer: randomized capture/replay against a map-array reference with directed fill, skew, overflow and abort steps.
module tb_pool1_fmap_buffer;
  localparam int NC = 6;
  localparam int MW = 14;
  localparam int RP = 2;
  localparam int DEPTH = MW * MW;
  localparam int TOTAL = RP * NC * DEPTH;
  logic clk = 1'b0, rst = 1'b1;
  logic [NC-1:0] valid_in = '0;
  logic [NC*8-1:0] pixel_in = '0;
  logic replay_start = 1'b0, out_ready = 1'b0;
  logic out_valid, out_last_map, out_last, buf_full, replay_done, overflow_err;
  logic [7:0] out_pixel;
  logic [2:0] out_ch;
  int checks = 0, errors = 0;
  bit ovf_exp = 0;
  logic [7:0] exp_mem [NC][DEPTH];
  pool1_fmap_buffer #(.NUM_CH(NC), .MAP_W(MW), .REPLAY_PASSES(RP)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .pixel_in(pixel_in), .replay_start(replay_start),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel), .out_ch(out_ch),
    .out_last_map(out_last_map), .out_last(out_last), .buf_full(buf_full),
    .replay_done(replay_done), .overflow_err(overflow_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  // Channels 0, 2 and 5 stream continuously (5 after its skew); others are bursty.
  task automatic capture(input bit pattern, input int skew5, input bit ovf2);
    int cnt [NC];
    bit done = 0, extra = 0;
    int cyc = 0;
    logic [7:0] px;
    for (int c = 0; c < NC; c++) cnt[c] = 0;
    while (!done && cyc < 2000) begin
      valid_in = '0;
      replay_start = 1'b0;
      if (ovf2 && !extra && cnt[2] == DEPTH) begin
        valid_in[2] = 1'b1;
        pixel_in[16 +: 8] = 8'hA5;
        extra = 1;
        ovf_exp = 1;
      end
      for (int c = 0; c < NC; c++)
        if (cnt[c] < DEPTH && cyc >= (c == 5 ? skew5 : 0) &&
            (pattern || c == 0 || c == 2 || c == 5 || $urandom_range(3, 0) != 0)) begin
          px = pattern ? 8'(c * 16 + cnt[c] % 16) : 8'($urandom);
          valid_in[c] = 1'b1;
          pixel_in[8*c +: 8] = px;
          exp_mem[c][cnt[c]] = px;
          cnt[c]++;
        end
      done = 1;
      for (int c = 0; c < NC; c++) if (cnt[c] != DEPTH) done = 0;
      if (pattern && done) replay_start = 1'b1;
      @(posedge clk); #1;
      cyc++;
      chk("buf_full", 32'(buf_full), 32'(done));
    end
    valid_in = '0;
    replay_start = 1'b0;
    chk("capture_ovf", 32'(overflow_err), 32'(ovf_exp));
  endtask
  task automatic replay(input int ready_pct, input int abort_at, input bit junk);
    int n = 0, cyc = 0, c, i;
    bit stalled = 0;
    logic [7:0] pp;
    logic [2:0] pc;
    logic pm, pl;
    replay_start = 1'b1;
    @(posedge clk); #1;
    replay_start = 1'b0;
    chk("lat_t1_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    chk("lat_t2_valid", 32'(out_valid), 1);
    while (n < TOTAL && cyc < 20000) begin
      valid_in = '0;
      if (stalled) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_pixel", 32'(out_pixel), 32'(pp));
        chk("stall_ch", 32'(out_ch), 32'(pc));
        chk("stall_last_map", 32'(out_last_map), 32'(pm));
        chk("stall_last", 32'(out_last), 32'(pl));
      end
      if (ready_pct == 100) chk("no_bubble", 32'(out_valid), 1);
      out_ready = $urandom_range(99, 0) < ready_pct;
      if (junk && n == 100) begin
        valid_in = '1;
        pixel_in = '1;
        ovf_exp = 1;
      end
      if (out_valid && out_ready) begin
        c = (n / DEPTH) % NC;
        i = n % DEPTH;
        chk("pixel", 32'(out_pixel), 32'(exp_mem[c][i]));
        chk("ch", 32'(out_ch), 32'(c));
        chk("last_map", 32'(out_last_map), 32'(i == DEPTH - 1));
        chk("last", 32'(out_last), 32'(n == TOTAL - 1));
        n++;
      end
      stalled = out_valid && !out_ready;
      pp = out_pixel; pc = out_ch; pm = out_last_map; pl = out_last;
      if (abort_at > 0 && n == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b0;
        valid_in = '0;
        ovf_exp = 0;
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_full", 32'(buf_full), 0);
        chk("abort_ovf", 32'(overflow_err), 0);
        chk("abort_done", 32'(replay_done), 0);
        return;
      end
      @(posedge clk); #1;
      cyc++;
      if (n < TOTAL) chk("done_early", 32'(replay_done), 0);
    end
    valid_in = '0;
    chk("transfers", 32'(n), 32'(TOTAL));
    chk("end_valid", 32'(out_valid), 0);
    chk("end_done", 32'(replay_done), 1);
    chk("end_full", 32'(buf_full), 0);
    chk("end_ovf", 32'(overflow_err), 32'(ovf_exp));
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("done_pulse", 32'(replay_done), 0);
    chk("idle_valid", 32'(out_valid), 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_pixel", 32'(out_pixel), 0);
    chk("rst_ch", 32'(out_ch), 0);
    chk("rst_last_map", 32'(out_last_map), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_full", 32'(buf_full), 0);
    chk("rst_done", 32'(replay_done), 0);
    chk("rst_ovf", 32'(overflow_err), 0);
    rst = 1'b0;
    capture(1, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("start_ignored", 32'(out_valid), 0);
    chk("still_full", 32'(buf_full), 1);
    replay(100, 0, 0);
    capture(0, 40, 1);
    replay(50, 0, 1);
    capture(0, 40, 0);
    replay(50, 500, 0);
    capture(0, 40, 0);
    replay(50, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pool1_fmap_buffer.md
Name: pool1_fmap_buffer

Overview:
- Collects the NUM_CH parallel pooled feature-map streams produced by the per-channel layer-1 conv/ReLU/maxpool stages (one int8 MAP_W x MAP_W map per channel) into on-chip RAM.
- Once every map is complete, replays the whole buffer REPLAY_PASSES times as a single valid/ready raster stream for the layer-2 convolution, which needs all input channels once per output channel.
- Sits between the layer-1 channel array and the layer-2 engine.

Parameters:
NUM_CH, 6, number of parallel input channels/maps
MAP_W, 14, map width and height (pooled 28x28 -> 14x14)
REPLAY_PASSES, 16, full-buffer replays per capture (one per layer-2 output channel)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
valid_in  in  NUM_CH  per-channel pixel strobe from the layer-1 channels
pixel_in  in  NUM_CH*8  packed signed int8 pixels; channel c at bits [8c+7:8c]
replay_start  in  1  single-cycle request to begin replay; honoured only in FULL
out_valid  out  1  out_pixel/out_ch/out_last_map/out_last valid
out_ready  in  1  downstream accepts when out_valid && out_ready
out_pixel  out  8  signed replayed pixel
out_ch  out  $clog2(NUM_CH)  channel index of out_pixel
out_last_map  out  1  high with the final pixel (row MAP_W-1, col MAP_W-1) of each channel map
out_last  out  1  high with the final pixel of the final pass
buf_full  out  1  high in state FULL
replay_done  out  1  one-cycle pulse after the final pixel is accepted
overflow_err  out  1  sticky error; cleared only by rst

Behaviour:
- Storage: NUM_CH*MAP_W*MAP_W bytes, synchronous-read RAM with 1-cycle read latency. Per-channel write counter: wcnt[c], 0..MAP_W*MAP_W. Contents are not cleared by rst.
- States: IDLE, CAPTURE, FULL, REPLAY.
- IDLE: any valid_in bit high -> write that pixel, go to CAPTURE.
- CAPTURE: for each c with valid_in[c] and wcnt[c] < MAP_W^2, write mem[c][wcnt[c]] (raster, row-major) and increment wcnt[c]. Channels are independent; all channels may write in the same cycle.
- CAPTURE -> FULL on the cycle after every wcnt[c] == MAP_W^2.
- Dropped pixels: valid_in[c] with wcnt[c] == MAP_W^2, or any valid_in in FULL or REPLAY, is dropped and sets overflow_err. The stored map is unchanged.
- FULL: buf_full=1. replay_start -> REPLAY. A replay_start in any other state is ignored, including the cycle the final capture write occurs.
- REPLAY output order: pass p = 0..REPLAY_PASSES-1; within each pass, channel c = 0..NUM_CH-1; within each channel, raster 0..MAP_W^2-1.
- Replay latency: replay_start sampled at cycle T -> out_valid first high at T+2 with pass 0, ch 0, pixel 0.
- Throughput: one pixel per cycle while out_ready is held high; no bubbles across channel or pass boundaries.
- Stall: while out_valid && !out_ready, out_pixel, out_ch, out_last_map and out_last hold stable. The read pipeline must not lose or duplicate a pixel. Implement as a 2-entry skid or prefetch register.
- out_valid never drops once asserted until the pixel is accepted.
- Completion: after the transfer with out_last=1, out_valid=0 next cycle, replay_done pulses for that cycle, all wcnt clear, state returns to IDLE.
- Reset values: out_valid=0, out_pixel=0, out_ch=0, out_last_map=0, out_last=0, buf_full=0, replay_done=0, overflow_err=0, state IDLE, all counters 0.
- Reset mid-capture or mid-replay: takes effect next edge; the stream is abandoned with no partial completion pulse.
- Counter widths: wcnt is $clog2(MAP_W*MAP_W+1) bits; pass counter is $clog2(REPLAY_PASSES) bits. No arithmetic on pixel data; bytes pass through bit-exact.

Test Plan:
- Capture fill: all 6 channels valid every cycle, pixel = ch*16 + (idx%16) for 196 cycles -> buf_full=1 on cycle 197; overflow_err=0.
- Skewed channels: ch0 finishes at cycle 196, ch5 starts 40 cycles late -> buf_full only after ch5's 196th pixel; no writes lost.
- Replay, out_ready=1, REPLAY_PASSES=2: out_valid at T+2, then 2352 consecutive transfers; out_ch steps every 196; out_last_map high on each 196th transfer; out_last on transfer 2352; replay_done at the next cycle; data matches capture.
- Backpressure: random 50% out_ready -> identical sequence with no drops or duplicates; outputs stable during every stall.
- Overflow: a 197th valid on ch2, plus a valid during REPLAY -> overflow_err=1 sticky; replayed data unchanged.
- Reset mid-replay at pixel 500 -> next cycle out_valid=0, IDLE, buf_full=0, overflow_err=0; a fresh capture/replay completes correctly.
